// File: rtl/bank_joltage.sv
// bank_joltage: streaming per-bank scorer for the day-3 battery datapath.
// Accepts one digit per beat, tracks the largest ordered two-digit pair in
// each bank and hands the result downstream over a valid/ready handshake.
// Optional feature macro: BANK_CHECK_EN adds the out_err port and flags
// malformed banks (too short, non-decimal digit, or too long).
module bank_joltage #(
  parameter int MAX_LEN = 100,
  parameter int LEN_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_digit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_value,
  output logic [LEN_W-1:0] out_len
`ifdef BANK_CHECK_EN
  ,
  output logic             out_err
`endif
);

  typedef enum logic {S_SCAN, S_EMIT} state_t;

  state_t           state;
  logic [3:0]       hi;
  logic [7:0]       best;
  logic [LEN_W-1:0] cnt;
  logic             seen;

  logic             accept;
  logic [7:0]       cand;
  logic [7:0]       best_next;
  logic [3:0]       hi_next;
  logic             at_max;
  logic [LEN_W-1:0] cnt_next;

`ifdef BANK_CHECK_EN
  logic             err;
  logic             err_next;
  logic             err_final;
`endif

  // Next tracker values for the beat being offered this cycle.
  always_comb begin
    accept    = in_valid && in_ready;
    cand      = ({4'd0, hi} * 8'd10) + {4'd0, in_digit};
    best_next = best;
    if (seen && (cand > best)) begin
      best_next = cand;
    end
    hi_next  = (in_digit > hi) ? in_digit : hi;
    at_max   = (cnt == LEN_W'(MAX_LEN));
    cnt_next = at_max ? cnt : (cnt + LEN_W'(1));
`ifdef BANK_CHECK_EN
    // A beat arriving while the count already sits at MAX_LEN overflows the bank.
    err_next  = err | (in_digit > 4'd9) | at_max;
    err_final = err_next | ~seen;
`endif
  end

  // Scan/emit FSM with registered handshake outputs, trackers and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_SCAN;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_value <= 8'd0;
      out_len   <= '0;
      hi        <= 4'd0;
      best      <= 8'd0;
      cnt       <= '0;
      seen      <= 1'b0;
`ifdef BANK_CHECK_EN
      err       <= 1'b0;
      out_err   <= 1'b0;
`endif
    end else begin
      case (state)
        S_SCAN: begin
          if (accept) begin
            hi   <= hi_next;
            best <= best_next;
            cnt  <= cnt_next;
            seen <= 1'b1;
`ifdef BANK_CHECK_EN
            err  <= err_next;
`endif
            if (in_last) begin
`ifdef BANK_CHECK_EN
              out_value <= err_final ? 8'd0 : best_next;
              out_err   <= err_final;
`else
              out_value <= best_next;
`endif
              out_len   <= cnt_next;
              state     <= S_EMIT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            hi        <= 4'd0;
            best      <= 8'd0;
            cnt       <= '0;
            seen      <= 1'b0;
`ifdef BANK_CHECK_EN
            err       <= 1'b0;
`endif
            state     <= S_SCAN;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_SCAN;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bank_joltage.sv
// tb_bank_joltage: directed-vector bench for bank_joltage with a pair-search
// reference model and a per-cycle compare process.
module tb_bank_joltage;

  localparam int MAX_LEN = 100;
  localparam int LEN_W   = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_digit = 4'd0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [7:0]       out_value;
  logic [LEN_W-1:0] out_len;
`ifdef BANK_CHECK_EN
  logic             out_err;
`endif

  typedef struct {
    int value;
    int len;
    int err;
  } res_t;

  int   passCount = 0;
  int   checkCount = 0;
  res_t expQ[$];
  int   partial[$];
  int   gotVals[$];
  int   gotLens[$];
  int   gotErrs[$];
  int   acceptedBeats = 0;
  int   lowCycles = 0;
  int   validRun = 0;
  int   lastValidWidth = 0;
  bit   latencyPending = 1'b0;
  bit   prevRst = 1'b0;

  bank_joltage #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digit  (in_digit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_len   (out_len)
`ifdef BANK_CHECK_EN
    ,
    .out_err   (out_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic void checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
  endfunction

  // Reference: best ordered pair by exhaustive search over the whole bank.
  function automatic res_t model(input int d[$]);
    res_t r;
    int   n;
    int   best;
    int   bad;
    n    = d.size();
    best = 0;
    bad  = (n < 2) ? 1 : 0;
    for (int i = 0; i < n; i++) begin
      if (d[i] > 9) bad = 1;
      for (int j = i + 1; j < n; j++) begin
        if (d[i] * 10 + d[j] > best) best = d[i] * 10 + d[j];
      end
    end
    if (n > MAX_LEN) bad = 1;
    r.len   = (n > MAX_LEN) ? MAX_LEN : n;
    r.value = best;
    r.err   = 0;
`ifdef BANK_CHECK_EN
    if (bad != 0) begin
      r.value = 0;
      r.err   = 1;
    end
`endif
    return r;
  endfunction

  // Compare process: observe handshakes, feed the model, check outputs every cycle.
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      partial.delete();
      latencyPending = 1'b0;
      validRun = 0;
    end else begin
      if (prevRst) begin
        checkOutput("reset_in_ready", int'(in_ready), 1);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_value", int'(out_value), 0);
        checkOutput("reset_out_len", int'(out_len), 0);
`ifdef BANK_CHECK_EN
        checkOutput("reset_out_err", int'(out_err), 0);
`endif
      end
      if (latencyPending) checkOutput("latency_out_valid", int'(out_valid), 1);
      latencyPending = 1'b0;
      checkOutput("out_valid_vs_model", int'(out_valid), (expQ.size() != 0) ? 1 : 0);
      checkOutput("in_ready_vs_out_valid", int'(in_ready), out_valid ? 0 : 1);
      if (out_valid) begin
        validRun++;
        if (expQ.size() != 0) begin
          checkOutput("out_value", int'(out_value), expQ[0].value);
          checkOutput("out_len", int'(out_len), expQ[0].len);
`ifdef BANK_CHECK_EN
          checkOutput("out_err", int'(out_err), expQ[0].err);
`endif
          if (out_ready) begin
            gotVals.push_back(int'(out_value));
            gotLens.push_back(int'(out_len));
`ifdef BANK_CHECK_EN
            gotErrs.push_back(int'(out_err));
`else
            gotErrs.push_back(0);
`endif
            void'(expQ.pop_front());
          end
        end
      end else begin
        if (validRun > 0) lastValidWidth = validRun;
        validRun = 0;
      end
      if (!in_ready) lowCycles++;
      if (in_valid && in_ready) begin
        acceptedBeats++;
        partial.push_back(int'(in_digit));
        if (in_last) begin
          expQ.push_back(model(partial));
          partial.delete();
          latencyPending = 1'b1;
        end
      end
    end
    prevRst = rst;
  end

  task automatic applyStimulus(input logic [3:0] d, input logic last);
    int waitCycles;
    waitCycles = 0;
    in_valid = 1'b1;
    in_digit = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && waitCycles < 200) begin
      waitCycles++;
      @(negedge clk);
    end
    if (!in_ready) checkOutput("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic sendBank(input string s);
    for (int i = 0; i < s.len(); i++) begin
      applyStimulus(4'(s[i] - 8'd48), (i == s.len() - 1));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual timeout, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int startLow;
    int snap;
    int sum;
    int expV[12];
    int expL[12];
    int expE[12];

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Single bank, downstream always ready.
    sendBank("987654321111111");
    idle(3);
    checkOutput("t1_valid_width", lastValidWidth, 1);

    // Four banks back-to-back: one in_ready bubble per bank.
    startLow = lowCycles;
    sendBank("987654321111111");
    sendBank("811111111111119");
    sendBank("234234234234278");
    sendBank("818181911112111");
    idle(3);
    checkOutput("b2b_ready_dips", lowCycles - startLow, 4);

    // Backpressure: hold the "34" result while the next bank waits.
    out_ready = 1'b0;
    sendBank("34");
    snap = acceptedBeats;
    fork
      sendBank("12");
      begin
        repeat (5) begin
          @(negedge clk);
          checkOutput("hold_value", int'(out_value), 34);
          checkOutput("hold_in_ready", int'(in_ready), 0);
        end
        checkOutput("hold_no_accept", acceptedBeats - snap, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(3);

    // Short bank and out-of-range digit.
    sendBank("5");
    applyStimulus(4'd1, 1'b0);
    applyStimulus(4'd12, 1'b0);
    applyStimulus(4'd3, 1'b1);
    idle(2);

    // Reset mid-bank discards the partial bank.
    applyStimulus(4'd9, 1'b0);
    applyStimulus(4'd9, 1'b0);
    applyStimulus(4'd9, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sendBank("12");
    idle(2);

    // Length boundary: exactly MAX_LEN digits, then MAX_LEN+2 digits.
    for (int i = 0; i < MAX_LEN - 1; i++) applyStimulus(4'd1, 1'b0);
    applyStimulus(4'd9, 1'b1);
    for (int i = 0; i < MAX_LEN + 1; i++) applyStimulus(4'd2, 1'b0);
    applyStimulus(4'd3, 1'b1);
    idle(5);

    expV = '{98, 98, 89, 78, 92, 34, 12, 0, 123, 12, 19, 23};
    expL = '{15, 15, 15, 15, 15, 2, 2, 1, 3, 2, 100, 100};
    expE = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`ifdef BANK_CHECK_EN
    expV[8]  = 0;
    expV[11] = 0;
    expE[7]  = 1;
    expE[8]  = 1;
    expE[11] = 1;
`endif
    checkOutput("result_count", gotVals.size(), 12);
    for (int k = 0; k < 12; k++) begin
      checkOutput($sformatf("lit_value_%0d", k), (k < gotVals.size()) ? gotVals[k] : -1, expV[k]);
      checkOutput($sformatf("lit_len_%0d", k), (k < gotLens.size()) ? gotLens[k] : -1, expL[k]);
      checkOutput($sformatf("lit_err_%0d", k), (k < gotErrs.size()) ? gotErrs[k] : -1, expE[k]);
    end
    sum = 0;
    for (int k = 1; k < 5; k++) sum += (k < gotVals.size()) ? gotVals[k] : 0;
    checkOutput("b2b_sum", sum, 357);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
